// File: rtl/lt_compare_scheduler.sv
// Round-robin scheduler that time-shares one external unsigned less-than
// comparator among R requesters, each with its own request/response channel.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | arbitrating; req_ready asserted for the granted requester
// S_COMPARE | granted operands sit on cmp_a/cmp_b, cmp_c is captured
// S_RESPOND | rsp_valid[id] held with rsp_lt until rsp_ready[id]
module lt_compare_scheduler #(
   parameter int N = 8,
   parameter int R = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [R-1:0]   req_valid,
   output logic [R-1:0]   req_ready,
   input  logic [R*N-1:0] req_a,
   input  logic [R*N-1:0] req_b,
   output logic [R-1:0]   rsp_valid,
   output logic           rsp_lt,
   input  logic [R-1:0]   rsp_ready,
   output logic [N-1:0]   cmp_a,
   output logic [N-1:0]   cmp_b,
   input  logic           cmp_c,
   output logic           busy
);

   localparam int IW = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW-1:0]  id_q, id_d;
   logic [N-1:0]   cmp_a_q, cmp_a_d;
   logic [N-1:0]   cmp_b_q, cmp_b_d;
   logic           result_q, result_d;
   logic [R-1:0]   rsp_valid_q, rsp_valid_d;
   logic           busy_q, busy_d;

   logic           grant_vld;
   logic [IW-1:0]  grant_idx;
   logic [R-1:0]   req_ready_c;
   int             scan_idx;

   // Rotating priority scan starting at ptr; only meaningful while idle.
   always_comb begin
      grant_vld   = 1'b0;
      grant_idx   = '0;
      req_ready_c = '0;
      scan_idx    = 0;
      if (state_q == S_IDLE) begin
         for (int k = 0; k < R; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= R) scan_idx = scan_idx - R;
            if (!grant_vld && req_valid[scan_idx]) begin
               grant_vld = 1'b1;
               grant_idx = IW'(scan_idx);
            end
         end
         if (grant_vld) req_ready_c[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      cmp_a_d     = cmp_a_q;
      cmp_b_d     = cmp_b_q;
      result_d    = result_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               cmp_a_d = req_a[grant_idx*N +: N];
               cmp_b_d = req_b[grant_idx*N +: N];
               id_d    = grant_idx;
               ptr_d   = (grant_idx == IW'(R-1)) ? '0 : grant_idx + IW'(1);
               state_d = S_COMPARE;
               busy_d  = 1'b1;
            end
         end
         S_COMPARE: begin
            result_d           = cmp_c;
            rsp_valid_d        = '0;
            rsp_valid_d[id_q]  = 1'b1;
            state_d            = S_RESPOND;
         end
         S_RESPOND: begin
            if (rsp_ready[id_q]) begin
               rsp_valid_d = '0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            rsp_valid_d = '0;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         cmp_a_q     <= '0;
         cmp_b_q     <= '0;
         result_q    <= 1'b0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         cmp_a_q     <= cmp_a_d;
         cmp_b_q     <= cmp_b_d;
         result_q    <= result_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_c;
   assign rsp_valid = rsp_valid_q;
   assign rsp_lt    = result_q;
   assign cmp_a     = cmp_a_q;
   assign cmp_b     = cmp_b_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lt_compare_scheduler.sv
// Bench for lt_compare_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the scheduler.
module tb_lt_compare_scheduler;

   localparam int N = 8;
   localparam int R = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [R-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [R*N-1:0] req_a, req_b;
   logic           rsp_lt;
   logic [N-1:0]   cmp_a, cmp_b;
   logic           cmp_c;
   logic           busy;

   always #5 clk = ~clk;

   assign cmp_c = (cmp_a < cmp_b);

   lt_compare_scheduler #(.N(N), .R(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_lt    (rsp_lt),
      .rsp_ready (rsp_ready),
      .cmp_a     (cmp_a),
      .cmp_b     (cmp_b),
      .cmp_c     (cmp_c),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: at most one transaction in flight, tracked by its age in cycles.
   bit           m_pend;
   int           m_id, m_age, m_ptr;
   logic [N-1:0] m_a, m_b, m_ca, m_cb;
   bit           auto_renew;
   int           g_who[$];
   int           g_when[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int grant_at(input int k);
      if (k < g_who.size()) return g_who[k];
      return -1;
   endfunction

   function automatic int when_at(input int k);
      if (k < g_when.size()) return g_when[k];
      return -100;
   endfunction

   task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
      req_a[i*N +: N] = a;
      req_b[i*N +: N] = b;
      req_valid[i]    = 1'b1;
   endtask

   task automatic cycle();
      int           g;
      logic [R-1:0] exp_ready, exp_rv, dut_g;
      @(negedge clk);
      g         = -1;
      exp_ready = '0;
      exp_rv    = '0;
      if (!m_pend)
         for (int k = 0; k < R; k++)
            if (g < 0 && req_valid[(m_ptr + k) % R]) g = (m_ptr + k) % R;
      if (g >= 0) exp_ready[g] = 1'b1;
      if (m_pend && m_age >= 2) exp_rv[m_id] = 1'b1;
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check_eq("busy", 32'(busy), 32'(m_pend));
      check_eq("cmp_a", 32'(cmp_a), 32'(m_ca));
      check_eq("cmp_b", 32'(cmp_b), 32'(m_cb));
      if (exp_rv != '0) check_eq("rsp_lt", 32'(rsp_lt), 32'(m_a < m_b));
      dut_g = req_ready & req_valid;
      for (int i = 0; i < R; i++)
         if (dut_g[i] && !rst) begin
            g_who.push_back(i);
            g_when.push_back(cyc);
         end
      if (rst) begin
         m_pend = 1'b0;
         m_ptr  = 0;
         m_ca   = '0;
         m_cb   = '0;
      end else if (g >= 0) begin
         m_pend = 1'b1;
         m_id   = g;
         m_age  = 1;
         m_a    = req_a[g*N +: N];
         m_b    = req_b[g*N +: N];
         m_ca   = m_a;
         m_cb   = m_b;
         m_ptr  = (g + 1) % R;
      end else if (m_pend) begin
         if (m_age >= 2 && rsp_ready[m_id]) m_pend = 1'b0;
         else m_age++;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < R; i++)
         if (dut_g[i] && !rst) begin
            if (auto_renew) set_req(i, N'($urandom), N'($urandom));
            else req_valid[i] = 1'b0;
         end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   int base;
   int rr_exp[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = '0;
      auto_renew = 1'b0;
      @(posedge clk);
      #1;
      m_pend = 1'b0;
      m_ptr  = 0;
      m_ca   = '0;
      m_cb   = '0;
      do_reset();
      check_eq("reset_rsp_lt", 32'(rsp_lt), 32'd0);
      run(2);

      // Single request from requester 2.
      rsp_ready = 4'b0100;
      set_req(2, 8'h05, 8'h09);
      base = g_who.size();
      run(4);
      check_eq("single_grant", 32'(grant_at(base)), 32'd2);

      // Boundary operand pairs from requester 1.
      rsp_ready = 4'hF;
      set_req(1, 8'hFF, 8'h00); run(4);
      set_req(1, 8'h00, 8'hFF); run(4);
      set_req(1, 8'h80, 8'h80); run(4);

      // Round robin with everyone requesting continuously.
      do_reset();
      auto_renew = 1'b1;
      for (int i = 0; i < R; i++) set_req(i, N'($urandom), N'($urandom));
      base = g_who.size();
      run(16);
      for (int k = 0; k < 5; k++) check_eq("rr_order", 32'(grant_at(base + k)), 32'(rr_exp[k]));
      for (int k = 0; k < 4; k++)
         check_eq("rr_spacing", 32'(when_at(base + k + 1) - when_at(base + k)), 32'd3);
      auto_renew = 1'b0;
      req_valid  = '0;
      run(4);

      // Pointer wrap: 3 granted, then 0 ahead of 3.
      do_reset();
      set_req(3, 8'h10, 8'h20);
      base = g_who.size();
      run(4);
      set_req(0, 8'h30, 8'h20);
      set_req(3, 8'h01, 8'h02);
      run(8);
      check_eq("wrap_g0", 32'(grant_at(base)), 32'd3);
      check_eq("wrap_g1", 32'(grant_at(base + 1)), 32'd0);
      check_eq("wrap_g2", 32'(grant_at(base + 2)), 32'd3);

      // Backpressure on requester 1; other rsp_ready bits must be ignored.
      do_reset();
      rsp_ready = '0;
      set_req(1, 8'h40, 8'h41);
      run(3);
      set_req(0, 8'h55, 8'h44);
      rsp_ready = 4'b1101;
      run(5);
      rsp_ready = 4'b0010;
      base = g_who.size();
      run(1);
      rsp_ready = 4'hF;
      run(1);
      check_eq("bp_grant0", 32'(grant_at(base)), 32'd0);
      check_eq("bp_grant0_when", 32'(when_at(base)), 32'(cyc - 1));
      run(4);

      // Reset during COMPARE drops the transaction.
      do_reset();
      set_req(2, 8'h01, 8'h07);
      run(1);
      do_reset();
      check_eq("midrst_busy", 32'(busy), 32'd0);
      set_req(0, 8'h09, 8'h03);
      set_req(2, 8'h02, 8'h08);
      base = g_who.size();
      run(10);
      check_eq("midrst_first", 32'(grant_at(base)), 32'd0);
      check_eq("midrst_second", 32'(grant_at(base + 1)), 32'd2);

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < R; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(2) == 0) set_req(i, N'($urandom), N'($urandom));
            end else if ($urandom_range(7) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = R'($urandom);
         rst = ($urandom_range(99) == 0);
         cycle();
      end
      rst = 1'b0;
      rsp_ready = '1;
      req_valid = '0;
      run(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
